// File: rtl/apu_pkg.sv
// Shared types and helpers for the APU output mixer.
// Holds the mixer state encoding, accumulator sizing and the output clamp.
package apu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE,
    OUT
  } mixer_state_t;

  // Wide enough to hold the sum of every channel at full scale.
  function automatic int acc_width(input int num_ch, input int sample_w);
    return sample_w + $clog2(num_ch);
  endfunction

  function automatic logic [63:0] sat_clamp(input logic [63:0] v, input int out_w);
    logic [63:0] lim;
    lim = (64'd1 << out_w) - 64'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/apu_sat_scale.sv
// Applies master volume to the accumulated mix and clamps it to the DAC width.
// Purely combinational; gain is (vol+1)/2^VOL_W.
module apu_sat_scale
  import apu_pkg::*;
#(
  parameter int ACC_W = 6,
  parameter int VOL_W = 3,
  parameter int OUT_W = 6
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [VOL_W-1:0] vol,
  output logic [OUT_W-1:0] result
);

  localparam int PROD_W = ACC_W + VOL_W + 1;

  logic [VOL_W:0]    gain;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] shifted;

  assign gain    = {1'b0, vol} + {{VOL_W{1'b0}}, 1'b1};
  assign prod    = PROD_W'(acc) * PROD_W'(gain);
  assign shifted = prod >> VOL_W;
  assign result  = OUT_W'(sat_clamp(64'(shifted), OUT_W));

endmodule

// File: rtl/apu_mixer_seq.sv
// Time-multiplexed APU mixer: snapshots all channels on a strobe, sums one channel
// per clock, scales by master volume and registers a saturated sample onto audio_out.
module apu_mixer_seq
  import apu_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 4,
  parameter int VOL_W    = 3,
  parameter int OUT_W    = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_strobe,
  input  logic [NUM_CH*SAMPLE_W-1:0]   ch_sample,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [VOL_W-1:0]             master_vol,
  output logic [OUT_W-1:0]             audio_out,
  output logic                         audio_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int ACC_W = acc_width(NUM_CH, SAMPLE_W);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  mixer_state_t         state;
  logic [SAMPLE_W-1:0]  ch_arr [NUM_CH];
  logic [SAMPLE_W-1:0]  samp_q [NUM_CH];
  logic [NUM_CH-1:0]    en_q;
  logic [VOL_W-1:0]     vol_q;
  logic [IDX_W-1:0]     idx;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     term;
  logic [OUT_W-1:0]     sat_res;
  logic [OUT_W-1:0]     sat_q;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_arr[i] = ch_sample[i*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_comb begin
    term = en_q[idx] ? ACC_W'(samp_q[idx]) : '0;
  end

  apu_sat_scale #(
    .ACC_W (ACC_W),
    .VOL_W (VOL_W),
    .OUT_W (OUT_W)
  ) u_sat_scale (
    .acc    (acc),
    .vol    (vol_q),
    .result (sat_res)
  );

  // Inputs are only sampled on an accepted strobe, so later changes never reach a mix in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      acc         <= '0;
      sat_q       <= '0;
      audio_out   <= '0;
      audio_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      en_q        <= '0;
      vol_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        samp_q[i] <= '0;
      end
    end else begin
      audio_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_strobe) begin
            samp_q <= ch_arr;
            en_q   <= ch_enable;
            vol_q  <= master_vol;
            acc    <= '0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          if (sample_strobe) overrun <= 1'b1;
          acc <= acc + term;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) state <= SCALE;
        end
        SCALE: begin
          if (sample_strobe) overrun <= 1'b1;
          sat_q <= sat_res;
          busy  <= 1'b0;
          state <= OUT;
        end
        OUT: begin
          audio_out   <= sat_q;
          audio_valid <= 1'b1;
          // A strobe landing here starts the next mix without a gap.
          if (sample_strobe) begin
            samp_q <= ch_arr;
            en_q   <= ch_enable;
            vol_q  <= master_vol;
            acc    <= '0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= ACCUM;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apu_mixer_seq.sv
// Self-checking bench for apu_mixer_seq: default, 8-channel and 1-channel instances.
module tb_apu_mixer_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        strobe = 1'b0;
  logic [15:0] samples = '0;
  logic [3:0]  en = '0;
  logic [2:0]  vol = '0;
  logic [5:0]  aout;
  logic        avalid, busy, ovr;

  logic        strobe8 = 1'b0;
  logic [31:0] samp8 = '0;
  logic [7:0]  en8 = '0;
  logic [2:0]  vol8 = '0;
  logic [4:0]  out8;
  logic        v8, busy8, ovr8;

  logic        strobe1 = 1'b0;
  logic [3:0]  samp1 = '0;
  logic [0:0]  en1 = '0;
  logic [2:0]  vol1 = '0;
  logic [5:0]  out1;
  logic        v1, busy1, ovr1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apu_mixer_seq dut (
    .clk(clk), .reset(reset), .sample_strobe(strobe), .ch_sample(samples),
    .ch_enable(en), .master_vol(vol), .audio_out(aout), .audio_valid(avalid),
    .busy(busy), .overrun(ovr)
  );

  apu_mixer_seq #(.NUM_CH(8), .OUT_W(5)) dut8 (
    .clk(clk), .reset(reset), .sample_strobe(strobe8), .ch_sample(samp8),
    .ch_enable(en8), .master_vol(vol8), .audio_out(out8), .audio_valid(v8),
    .busy(busy8), .overrun(ovr8)
  );

  apu_mixer_seq #(.NUM_CH(1)) dut1 (
    .clk(clk), .reset(reset), .sample_strobe(strobe1), .ch_sample(samp1),
    .ch_enable(en1), .master_vol(vol1), .audio_out(out1), .audio_valid(v1),
    .busy(busy1), .overrun(ovr1)
  );

  // Reference: sum of enabled 4-bit samples, times (vol+1)/8, clipped to the output range.
  function automatic int mix_ref(input logic [31:0] s, input logic [7:0] e, input int n,
                                 input int v, input int out_w);
    int sum;
    int scaled;
    int lim;
    sum = 0;
    for (int i = 0; i < n; i++) if (e[i]) sum += int'(s[i*4 +: 4]);
    scaled = (sum * (v + 1)) / 8;
    lim = (1 << out_w) - 1;
    return (scaled > lim) ? lim : scaled;
  endfunction

  // Runs one mix on the default instance; inputs are scrambled right after the strobe edge.
  task automatic do_mix(input logic [15:0] s, input logic [3:0] e, input logic [2:0] v,
                        output int lat, output int res, output int bcnt);
    samples = s; en = e; vol = v; strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
    samples = 16'($urandom); en = 4'($urandom); vol = 3'($urandom);
    bcnt = int'(busy); lat = -1; res = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (avalid) begin lat = k; res = int'(aout); break; end
      bcnt += int'(busy);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++; if (aout !== 6'd0) begin errors++; $display("FAIL reset_out got %0d exp 0", aout); end
    checks++; if (avalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", avalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b exp 0", ovr); end
    #10 reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (avalid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL idle_after_reset valid %0b busy %0b exp 0 0", avalid, busy);
      end
    end
  endtask

  task automatic test_full_scale;
    int lat, res, bcnt;
    do_mix(16'hFFFF, 4'b1111, 3'd7, lat, res, bcnt);
    checks++; if (res !== 60) begin errors++; $display("FAIL full_scale_out got %0d exp 60", res); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL full_scale_latency got %0d exp 6", lat); end
    checks++; if (bcnt !== 5) begin errors++; $display("FAIL full_scale_busy got %0d exp 5", bcnt); end
    @(posedge clk); #1;
    checks++; if (avalid !== 1'b0) begin errors++; $display("FAIL valid_one_cycle got %0b exp 0", avalid); end
    checks++; if (aout !== 6'd60) begin errors++; $display("FAIL out_hold got %0d exp 60", aout); end
  endtask

  task automatic test_vol_enables;
    int lat, res, bcnt;
    do_mix({4'd1, 4'd3, 4'd9, 4'd5}, 4'b0101, 3'd7, lat, res, bcnt);
    checks++; if (res !== 8) begin errors++; $display("FAIL enables_vol7 got %0d exp 8", res); end
    do_mix({4'd1, 4'd3, 4'd9, 4'd5}, 4'b0101, 3'd3, lat, res, bcnt);
    checks++; if (res !== 4) begin errors++; $display("FAIL enables_vol3 got %0d exp 4", res); end
    do_mix(16'hFFFF, 4'b1111, 3'd3, lat, res, bcnt);
    checks++; if (res !== 30) begin errors++; $display("FAIL full_vol3 got %0d exp 30", res); end
    do_mix(16'hFFFF, 4'b0000, 3'd7, lat, res, bcnt);
    checks++; if (res !== 0 || lat !== 6) begin
      errors++; $display("FAIL all_disabled got %0d lat %0d exp 0 lat 6", res, lat);
    end
  endtask

  task automatic test_random;
    int lat, res, bcnt, exp_v;
    logic [15:0] s;
    logic [3:0]  e;
    logic [2:0]  v;
    for (int i = 0; i < 12; i++) begin
      s = 16'($urandom); e = 4'($urandom); v = 3'($urandom);
      exp_v = mix_ref({16'd0, s}, {4'd0, e}, 4, int'(v), 6);
      do_mix(s, e, v, lat, res, bcnt);
      checks++; if (res !== exp_v || lat !== 6) begin
        errors++; $display("FAIL random_mix[%0d] got %0d lat %0d exp %0d lat 6", i, res, lat, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back;
    int exp_q[$];
    for (int m = 0; m < 6; m++) begin
      samples = 16'($urandom); en = 4'($urandom); vol = 3'($urandom); strobe = 1'b1;
      exp_q.push_back(mix_ref({16'd0, samples}, {4'd0, en}, 4, int'(vol), 6));
      @(posedge clk); #1;
      strobe = 1'b0;
      if (m > 0) begin
        checks++; if (avalid !== 1'b1 || int'(aout) !== exp_q[m-1]) begin
          errors++; $display("FAIL b2b_result[%0d] valid %0b got %0d exp 1 %0d", m-1, avalid, aout, exp_q[m-1]);
        end
      end
      samples = 16'($urandom); en = 4'($urandom); vol = 3'($urandom);
      repeat (5) begin
        @(posedge clk); #1;
        checks++; if (avalid !== 1'b0) begin errors++; $display("FAIL b2b_spurious_valid got 1 exp 0"); end
      end
    end
    @(posedge clk); #1;
    checks++; if (avalid !== 1'b1 || int'(aout) !== exp_q[5]) begin
      errors++; $display("FAIL b2b_result[5] valid %0b got %0d exp 1 %0d", avalid, aout, exp_q[5]);
    end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %0b exp 0", ovr); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_overrun;
    int exp_a, nvalid, val, lat, res, bcnt;
    samples = 16'h3A7C; en = 4'b1011; vol = 3'd5; strobe = 1'b1;
    exp_a = mix_ref({16'd0, samples}, {4'd0, en}, 4, int'(vol), 6);
    @(posedge clk); #1;
    strobe = 1'b0; samples = 16'hFFFF; en = 4'b1111; vol = 3'd7;
    @(posedge clk); #1;
    strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
    nvalid = 0; val = -1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (avalid) begin nvalid++; val = int'(aout); end
    end
    checks++; if (nvalid !== 1) begin errors++; $display("FAIL overrun_valid_count got %0d exp 1", nvalid); end
    checks++; if (val !== exp_a) begin errors++; $display("FAIL overrun_first_result got %0d exp %0d", val, exp_a); end
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL overrun_flag got %0b exp 1", ovr); end
    do_mix(16'hFFFF, 4'b1111, 3'd7, lat, res, bcnt);
    checks++; if (res !== 60) begin errors++; $display("FAIL overrun_next_mix got %0d exp 60", res); end
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %0b exp 1", ovr); end
  endtask

  task automatic test_reset_midmix;
    int nvalid, lat, res, bcnt, exp_v;
    samples = 16'h5555; en = 4'b1111; vol = 3'd7; strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    checks++; if (aout !== 6'd0) begin errors++; $display("FAIL midmix_out got %0d exp 0", aout); end
    checks++; if (busy !== 1'b0 || avalid !== 1'b0) begin
      errors++; $display("FAIL midmix_busy_valid got %0b %0b exp 0 0", busy, avalid);
    end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL midmix_overrun got %0b exp 0", ovr); end
    #10 reset = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (avalid) nvalid++;
    end
    checks++; if (nvalid !== 0) begin errors++; $display("FAIL midmix_no_valid got %0d exp 0", nvalid); end
    exp_v = mix_ref(32'h0000_9E2D, 8'h0E, 4, 6, 6);
    do_mix(16'h9E2D, 4'b1110, 3'd6, lat, res, bcnt);
    checks++; if (res !== exp_v || lat !== 6) begin
      errors++; $display("FAIL midmix_recover got %0d lat %0d exp %0d lat 6", res, lat, exp_v);
    end
  endtask

  task automatic test_generality;
    int lat, res, exp_v;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin samp8 = 32'hFFFF_FFFF; en8 = 8'hFF; vol8 = 3'd7; end
      else begin samp8 = $urandom; en8 = 8'($urandom); vol8 = 3'($urandom); end
      exp_v = mix_ref(samp8, en8, 8, int'(vol8), 5);
      strobe8 = 1'b1;
      @(posedge clk); #1;
      strobe8 = 1'b0; samp8 = $urandom; en8 = 8'($urandom);
      lat = -1; res = -1;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        if (v8) begin lat = k; res = int'(out8); break; end
      end
      checks++; if (lat !== 10) begin errors++; $display("FAIL ch8_latency[%0d] got %0d exp 10", i, lat); end
      checks++; if (res !== exp_v) begin errors++; $display("FAIL ch8_out[%0d] got %0d exp %0d", i, res, exp_v); end
    end
    for (int i = 0; i < 3; i++) begin
      samp1 = 4'($urandom); en1 = 1'b1; vol1 = 3'd7;
      exp_v = int'(samp1);
      strobe1 = 1'b1;
      @(posedge clk); #1;
      strobe1 = 1'b0; samp1 = 4'($urandom);
      lat = -1; res = -1;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        if (v1) begin lat = k; res = int'(out1); break; end
      end
      checks++; if (lat !== 3) begin errors++; $display("FAIL ch1_latency[%0d] got %0d exp 3", i, lat); end
      checks++; if (res !== exp_v) begin errors++; $display("FAIL ch1_out[%0d] got %0d exp %0d", i, res, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_vol_enables();
    test_random();
    test_back_to_back();
    test_overrun();
    test_reset_midmix();
    test_generality();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apu_mixer_seq.md
Name: apu_mixer_seq

Overview:
Parametrised, time-multiplexed audio mixer for the APU output stage. It replaces the fixed 4-channel, 4-bit summing path with a design generalised in channel count, sample width, output width and master volume. It adds per-channel enables, saturation and a sample-strobe/valid handshake. Each mix is a snapshot of all channel samples, accumulated one channel per clock, then scaled and registered onto the DAC-facing audio_out.

Parameters:
NUM_CH, 4, number of input channels (>=1)
SAMPLE_W, 4, unsigned bits per channel sample
VOL_W, 3, master volume width; gain = (master_vol+1)/2^VOL_W
OUT_W, 6, output width; results above 2^OUT_W-1 saturate

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sample_strobe  in  1  one-cycle request to start a mix
ch_sample  in  NUM_CH*SAMPLE_W  packed samples; channel i at [i*SAMPLE_W +: SAMPLE_W]
ch_enable  in  NUM_CH  per-channel enable; 0 contributes zero
master_vol  in  VOL_W  master volume
audio_out  out  OUT_W  registered mixed sample; holds between updates
audio_valid  out  1  one-cycle pulse when audio_out updates
busy  out  1  high while state is ACCUM or SCALE
overrun  out  1  sticky; set when a strobe is dropped

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, acc=0, audio_out=0, audio_valid=0, busy=0, overrun=0.
- States: IDLE, ACCUM, SCALE, OUT.
- Accepting a strobe: a strobe is accepted when state is IDLE or OUT. At that edge, ch_sample, ch_enable and master_vol are latched, acc=0, idx=0, and the state goes to ACCUM.
- Dropped strobe: a strobe in ACCUM or SCALE is dropped and sets overrun=1. overrun stays set until reset.
- ACCUM: each edge does acc += enable[idx] ? sample[idx] : 0, then idx++. After the channel NUM_CH-1 edge, the state goes to SCALE. ACC_W = SAMPLE_W + clog2(NUM_CH); acc never overflows.
- SCALE: one edge registers prod = acc*(vol+1) >> VOL_W. prod width is ACC_W+VOL_W+1 before the shift.
- OUT: the entry edge registers audio_out = min(prod, 2^OUT_W-1) and audio_valid=1 for exactly one cycle. The next edge returns to IDLE, or re-enters ACCUM if a strobe is present.
- Latency: the strobe is sampled at edge E0. audio_out and audio_valid change at edge E(NUM_CH+2). The minimum accepted strobe period is NUM_CH+2 cycles; back-to-back strobes at this period produce no overrun.
- Input changes after E0 do not affect the mix in flight.
- All enables 0: audio_out=0, and audio_valid still pulses.
- audio_valid is 0 in every state except the cycle after the OUT entry edge.

Decomposition:
- Package apu_pkg holds:
  - typedef enum mixer_state_t {IDLE, ACCUM, SCALE, OUT};
  - localparam function for ACC_W;
  - a saturating-clamp function.
- One sub-module, apu_sat_scale: combinational (acc, vol) -> clamped OUT_W result, parametrised by ACC_W, VOL_W and OUT_W. It is instantiated between the SCALE register and the audio_out register.
- The FSM, accumulator and handshake stay in apu_mixer_seq.

Test Plan:
1. Full scale: defaults, samples 15,15,15,15, enables 4'b1111, vol 7, strobe -> audio_out=60 and one valid pulse exactly 6 edges after the strobe; busy high for 5 cycles.
2. Volume and enables:
   - samples ch0=5, ch1=9, ch2=3, ch3=1, enables 4'b0101, vol 7 -> 8;
   - same inputs with vol 3 -> 4;
   - 60 with vol 3 -> 30.
3. Overrun: strobe, then a second strobe 2 cycles later -> one valid only, first result intact, overrun=1 and held. A further strobe at a legal period still mixes, and overrun stays 1.
4. Back-to-back: strobes every 6 cycles with samples changed immediately after each strobe -> valid every 6 cycles, each result matches the snapshot taken at its own strobe, overrun=0.
5. Reset mid-mix: assert reset asynchronously (off clock edge) during ACCUM -> outputs immediately 0 and no valid afterwards. The next strobe after release produces a correct result.
6. Saturation and generality: NUM_CH=8, OUT_W=5, all samples 15 enabled, vol 7 -> audio_out=31 with latency 10. NUM_CH=1 -> latency 3 and audio_out equal to the sample.
